// File: rtl/cim_pkg.sv
// Shared encodings for the compute-in-memory controller: command ops, FSM states
// and the phase counter width.
package cim_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_MAC     = 2'b01,
        OP_SEARCH  = 2'b10,
        OP_ILLEGAL = 2'b11
    } cim_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        WR    = 3'd2,
        MAC_P = 3'd3,
        MAC_N = 3'd4,
        SRCH  = 3'd5,
        DONE  = 3'd6
    } cim_state_e;

    localparam int CNT_W = 8;

    // Phase length of 0 behaves like 1: the counter loads CYC-1 and exits on 0.
    function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
        return (cyc <= 1) ? '0 : CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/cim_ctrl.sv
// Command sequencer for a CIM array: turns WRITE / MAC / SEARCH commands into
// registered row-decoder controls and returns one response per command.
module cim_ctrl
    import cim_pkg::*;
#(
    parameter int WR_CYC   = 2,
    parameter int MAC_CYC  = 2,
    parameter int SRCH_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_addr,
    input  logic [3:0] cmd_data,
    input  logic [3:0] sa_out,
    output logic       cs,
    output logic       MAC_en,
    output logic       read_bar,
    output logic       w_en,
    output logic [1:0] addr,
    output logic [3:0] data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] WR_LD   = cyc_load(WR_CYC);
    localparam logic [CNT_W-1:0] MAC_LD  = cyc_load(MAC_CYC);
    localparam logic [CNT_W-1:0] SRCH_LD = cyc_load(SRCH_CYC);

    cim_state_e       state_q, state_d;
    cim_op_e          op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       addr_q, addr_d;
    logic [3:0]       data_q, data_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             cs_q, cs_d;
    logic             mac_en_q, mac_en_d;
    logic             read_bar_q, read_bar_d;
    logic             w_en_q, w_en_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d    = PRE;
                    op_d       = cim_op_e'(cmd_op);
                    addr_d     = cmd_addr;
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end
            end
            PRE: begin
                unique case (op_q)
                    OP_WRITE:   begin state_d = WR;    cnt_d = WR_LD;   end
                    OP_MAC:     begin state_d = MAC_P; cnt_d = MAC_LD;  end
                    OP_SEARCH:  begin state_d = SRCH;  cnt_d = SRCH_LD; end
                    OP_ILLEGAL: begin state_d = DONE;  rsp_err_d = 1'b1; end
                endcase
            end
            WR: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            MAC_P: begin
                if (cnt_q == '0) begin
                    state_d          = MAC_N;
                    cnt_d            = MAC_LD;
                    rsp_data_d[7:4]  = sa_out;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MAC_N: begin
                if (cnt_q == '0) begin
                    state_d          = DONE;
                    rsp_data_d[3:0]  = sa_out;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SRCH: begin
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    rsp_data_d = {4'h0, sa_out};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Decoder controls are decoded from the next state so the registered
        // copies line up exactly with the state they belong to.
        cs_d       = (state_d == WR) || (state_d == MAC_P) ||
                     (state_d == MAC_N) || (state_d == SRCH);
        w_en_d     = (state_d == WR);
        mac_en_d   = (state_d == MAC_P) || (state_d == MAC_N);
        read_bar_d = (state_d == MAC_N);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_WRITE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cs_q       <= 1'b0;
            mac_en_q   <= 1'b0;
            read_bar_q <= 1'b0;
            w_en_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cs_q       <= cs_d;
            mac_en_q   <= mac_en_d;
            read_bar_q <= read_bar_d;
            w_en_q     <= w_en_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign cs        = cs_q;
    assign MAC_en    = mac_en_q;
    assign read_bar  = read_bar_q;
    assign w_en      = w_en_q;
    assign addr      = addr_q;
    assign data      = data_q;

endmodule
